regfile_operand_stage: RTL
==========================

// Module: regfile_operand_stage
// PURPOSE
// - Operand-fetch stage directly upstream of the 16-bit shifter/ALU path.
// - Holds an 8-entry x 16-bit register file with one write port and two read ports.
// - On an accepted read request, registers the A and B operands plus the 2-bit shift
//   code and presents them with a valid/ready handshake. B and the shift code drive
//   the shifter inputs; A drives the ALU's other operand.
// PARAMETERS
// - DATA_W  16  operand / register width
// - NREGS    8  number of registers
// - ADDR_W   3  register index width; NREGS == 2**ADDR_W
// PORTS
// - clk         in   1       clock; all state updates on rising edge
// - reset       in   1       synchronous, active-high reset
// - write       in   1       write enable for register file
// - writenum    in   ADDR_W  register written when write=1
// - data_in     in   DATA_W  write data
// - rd_req      in   1       request operand fetch
// - rd_ready    out  1       stage can accept rd_req this cycle
// - readnum_a   in   ADDR_W  A operand register index
// - readnum_b   in   ADDR_W  B operand register index
// - shift_in    in   2       shift code forwarded with operands (00 none, 01 lsl, 10 lsr, 11 asr)
// - out_valid   out  1       a_out/b_out/shift_out hold a valid operand set
// - out_ready   in   1       downstream consumes operand set when out_valid=1
// - a_out       out  DATA_W  registered A operand
// - b_out       out  DATA_W  registered B operand (to shifter in)
// - shift_out   out  2       registered shift code (to shifter shift)
// BEHAVIOUR
// - Reset (sync, reset=1 at edge): all NREGS registers <= 0; a_out, b_out <= 0;
//   shift_out <= 2'b00; out_valid <= 0; FSM -> EMPTY. Reset takes priority over
//   write and rd_req in the same cycle; an in-flight operand set is discarded.
// - FSM states: EMPTY (out_valid=0), FULL (out_valid=1).
//   - EMPTY: rd_req=1 -> capture operands, go FULL next cycle.
//   - FULL: out_ready=1 & rd_req=1 -> capture new set, stay FULL (back-to-back, no bubble).
//   - FULL: out_ready=1 & rd_req=0 -> EMPTY.
//   - FULL: out_ready=0 -> hold a_out/b_out/shift_out stable; rd_req ignored.
// - rd_ready = (state==EMPTY) | out_ready; combinational. rd_req with rd_ready=0 is
//   ignored (not queued); requester must hold it.
// - Latency: rd_req accepted at edge N -> out_valid=1 with data after edge N
//   (1 cycle). Capture: a_out <= R[readnum_a], b_out <= R[readnum_b], shift_out <= shift_in.
// - Write: write=1 at edge -> R[writenum] <= data_in. Writes proceed in every state,
//   independent of handshake, including while FULL/stalled.
// - readnum_a == readnum_b is legal; both outputs get same value.
// - Held outputs are not updated by later writes to the source register (snapshot).
// - No arithmetic; widths pass through unchanged. Indices are full-range (no wrap).
// CONFIGURATION
// - WRITE_BYPASS_EN defined: if write=1 and writenum matches readnum_a/readnum_b in the
//   same cycle an operand capture occurs, the captured value is data_in (write-through).
// - WRITE_BYPASS_EN undefined: captured value is the register's pre-write contents;
//   the new value is visible to captures from the next cycle.
// TESTING
// - Reset: drive reset=1 one cycle -> out_valid=0, a_out=b_out=0, read of R3 after
//   reset yields 0x0000.
// - Write R2=0x8001, R5=0x00F0, then rd_req a=5 b=2 shift=11 -> one cycle later
//   out_valid=1, a_out=0x00F0, b_out=0x8001, shift_out=2'b11.
// - Stall: out_ready=0 for 4 cycles while rd_req=1 with new indices and R2 rewritten
//   to 0x1234 -> outputs stay 0x00F0/0x8001, rd_ready=0; on out_ready=1 next set loads.
// - Back-to-back: out_ready=1, rd_req=1 for 3 cycles on R1,R2,R3 -> out_valid stays 1,
//   b_out sequence R1,R2,R3 with no bubble.
// - Collision: R4=0x0001, then same cycle write R4=0xAAAA and rd_req b=4 ->
//   b_out=0xAAAA with WRITE_BYPASS_EN, 0x0001 without.
// - Reset while FULL with out_ready=0 -> next cycle out_valid=0, all regs 0.

Source files
------------

// File: rtl/regfile_operand_stage.sv
// regfile_operand_stage: 8x16 register file with a registered A/B/shift operand slot behind a valid/ready handshake.
// Define WRITE_BYPASS_EN to let a same-cycle write feed through to the captured operands.
module regfile_operand_stage #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] writenum,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_req,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] readnum_a,
  input  logic [ADDR_W-1:0] readnum_b,
  input  logic [1:0]        shift_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [1:0]        shift_out
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] a_q, b_q, rd_a, rd_b;
  logic [1:0] shift_q;
  logic cap;
`ifdef WRITE_BYPASS_EN
  assign rd_a = (write && writenum == readnum_a) ? data_in : regs_q[readnum_a];
  assign rd_b = (write && writenum == readnum_b) ? data_in : regs_q[readnum_b];
`else
  assign rd_a = regs_q[readnum_a];
  assign rd_b = regs_q[readnum_b];
`endif
  always_comb begin
    rd_ready = (state_q == EMPTY) | out_ready;
    cap      = rd_req & rd_ready;
    state_d  = cap ? FULL : (out_ready ? EMPTY : state_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      a_q     <= '0;
      b_q     <= '0;
      shift_q <= 2'b00;
      state_q <= EMPTY;
    end else begin
      if (write) regs_q[writenum] <= data_in;
      if (cap) begin
        a_q     <= rd_a;
        b_q     <= rd_b;
        shift_q <= shift_in;
      end
      state_q <= state_d;
    end
  end
  assign out_valid = (state_q == FULL);
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign shift_out = shift_q;
endmodule
